// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: decode redirect/control inputs, the memory read path, and the
// IF/ID, fetch-count and fault outputs seen by the rest of the pipeline.
interface instruction_fetch_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  stall_i;
    logic                  flush_i;
    logic                  branch_taken_i;
    logic [DATA_WIDTH-1:0] branch_offset_i;
    logic                  jump_i;
    logic [25:0]           jump_index_i;
    logic                  jump_reg_i;
    logic [DATA_WIDTH-1:0] jump_reg_addr_i;
    logic [DATA_WIDTH-1:0] instruction_i;

    logic [DATA_WIDTH-1:0] pc_o;
    logic [DATA_WIDTH-1:0] if_id_instruction_o;
    logic [DATA_WIDTH-1:0] if_id_pc_plus4_o;
    logic                  if_id_valid_o;
    logic [31:0]           fetch_count_o;
    logic                  fault_o;
    logic [DATA_WIDTH-1:0] fault_addr_o;

    // The fetch unit drives the address and the IF/ID stage.
    modport master (
        input  stall_i, flush_i, branch_taken_i, branch_offset_i, jump_i,
               jump_index_i, jump_reg_i, jump_reg_addr_i, instruction_i,
        output pc_o, if_id_instruction_o, if_id_pc_plus4_o, if_id_valid_o,
               fetch_count_o, fault_o, fault_addr_o
    );

    modport slave (
        output stall_i, flush_i, branch_taken_i, branch_offset_i, jump_i,
               jump_index_i, jump_reg_i, jump_reg_addr_i, instruction_i,
        input  pc_o, if_id_instruction_o, if_id_pc_plus4_o, if_id_valid_o,
               fetch_count_o, fault_o, fault_addr_o
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC register, next-PC selection from decode redirects,
// IF/ID pipeline register, and a sticky fault on fetch targets outside the text window.
module instruction_fetch_unit #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           MEMORY_DEPTH = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000
) (
    input logic                      clk,
    input logic                      reset,
    instruction_fetch_unit_if.master bus
);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FAULT = 1'b1;

    localparam logic [DATA_WIDTH-1:0] LAST_PC =
        RESET_PC + DATA_WIDTH'(4 * MEMORY_DEPTH - 4);

    logic [0:0]            state;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] if_instr;
    logic [DATA_WIDTH-1:0] if_pc_plus4;
    logic                  if_valid;
    logic [31:0]           fetch_count;
    logic                  fault;
    logic [DATA_WIDTH-1:0] fault_addr;

    logic [DATA_WIDTH-1:0] seq_pc;
    logic [DATA_WIDTH-1:0] target;
    logic                  redirect;
    logic                  legal;

    // Redirects belong to the instruction in IF/ID, so a bubble there cannot redirect.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        seq_pc   = pc + DATA_WIDTH'(4);
        target   = seq_pc;
        redirect = 1'b0;
        if (if_valid) begin
            if (bus.jump_reg_i) begin
                target   = bus.jump_reg_addr_i;
                redirect = 1'b1;
            end else if (bus.jump_i) begin
                target   = {if_pc_plus4[DATA_WIDTH-1 -: 4], bus.jump_index_i, 2'b00};
                redirect = 1'b1;
            end else if (bus.branch_taken_i) begin
                target   = if_pc_plus4 + (bus.branch_offset_i << 2);
                redirect = 1'b1;
            end
        end
    end

    assign legal = (target[1:0] == 2'b00) && (target >= RESET_PC) && (target <= LAST_PC);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every update sees pre-edge values.
        if (!reset) begin
            state       <= ST_RUN;
            pc          <= RESET_PC;
            if_instr    <= '0;
            if_pc_plus4 <= '0;
            if_valid    <= 1'b0;
            fetch_count <= '0;
            fault       <= 1'b0;
            fault_addr  <= '0;
        end else if (state == ST_RUN && !bus.stall_i) begin
            if (legal) begin
                pc <= target;
                // Wrong-path fetch after a redirect is squashed; there are no delay slots.
                if (bus.flush_i || redirect) begin
                    if_instr    <= '0;
                    if_pc_plus4 <= '0;
                    if_valid    <= 1'b0;
                end else begin
                    if_instr    <= bus.instruction_i;
                    if_pc_plus4 <= seq_pc;
                    if_valid    <= 1'b1;
                    fetch_count <= fetch_count + 32'd1;
                end
            end else begin
                fault_addr <= target;
                fault      <= 1'b1;
                if_valid   <= 1'b0;
                if_instr   <= '0;
                state      <= ST_FAULT;
            end
        end
    end

    assign bus.pc_o                = pc;
    assign bus.if_id_instruction_o = if_instr;
    assign bus.if_id_pc_plus4_o    = if_pc_plus4;
    assign bus.if_id_valid_o       = if_valid;
    assign bus.fetch_count_o       = fetch_count;
    assign bus.fault_o             = fault;
    assign bus.fault_addr_o        = fault_addr;
endmodule
